rgb_sinp: RTL and testbench

Serial input decoder for the WS2812b RGB LED stream. Samples the single-wire input on the 96 MHz PLL clock and classifies each high pulse as a 0 or 1 bit. Assembles 24 bits (G-R-B, MSB first) into one 32-bit status/colour word and pushes it into the FIFO. The downstream RGBW serial-output stage reads that FIFO; stream-reset gaps become stream-reset words in the FIFO.

---
 rtl/rgb_pkg.sv | 52 +++++
 rtl/rgb_sinp_sync.sv | 38 +++
 rtl/rgb_sinp.sv | 209 ++++++++++++++++++++
 tb/tb_rgb_sinp.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared definitions for the WS2812b serial-in decoder and the RGBW serial-out stage:
// FIFO word layout, status bytes, decoder state encoding and word builders.
package rgb_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned BITS_PER_WORD = 24;

    localparam int unsigned BIT_VALID     = 31;
    localparam int unsigned BIT_STR_RST   = 30;
    localparam int unsigned BIT_PARTIAL   = 29;
    localparam int unsigned G_MSB         = 23;
    localparam int unsigned G_LSB         = 16;
    localparam int unsigned R_MSB         = 15;
    localparam int unsigned R_LSB         = 8;
    localparam int unsigned B_MSB         = 7;
    localparam int unsigned B_LSB         = 0;

    localparam logic [7:0] STATUS_DATA    = 8'h80;
    localparam logic [7:0] STATUS_STR_RST = 8'hC0;

    localparam int unsigned STATE_W       = 2;
    localparam logic [STATE_W-1:0] ST_IDLE_LOW  = 2'd0;
    localparam logic [STATE_W-1:0] ST_MEAS_HIGH = 2'd1;
    localparam logic [STATE_W-1:0] ST_ERR_HIGH  = 2'd2;
    localparam logic [STATE_W-1:0] ST_MEAS_LOW  = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        IDLE_LOW  = ST_IDLE_LOW,
        MEAS_HIGH = ST_MEAS_HIGH,
        ERR_HIGH  = ST_ERR_HIGH,
        MEAS_LOW  = ST_MEAS_LOW
    } sinp_state_e;

    // Colour word: status byte, then G, R, B.
    function automatic logic [WORD_W-1:0] data_word(input logic [BITS_PER_WORD-1:0] grb);
        logic [WORD_W-1:0] w;
        w = {STATUS_DATA, 24'h0};
        w[G_MSB:G_LSB] = grb[23:16];
        w[R_MSB:R_LSB] = grb[15:8];
        w[B_MSB:B_LSB] = grb[7:0];
        return w;
    endfunction

    // Stream-reset word; partial flags that some bits were pending when the gap hit.
    function automatic logic [WORD_W-1:0] str_rst_word(input logic partial);
        logic [WORD_W-1:0] w;
        w = {STATUS_STR_RST, 24'h0};
        w[BIT_PARTIAL] = partial;
        return w;
    endfunction

endpackage

// File: rtl/rgb_sinp_sync.sv
// Two-flop synchronizer for the asynchronous serial input, with rise/fall detection
// on the synchronized level.
module rgb_sinp_sync (
    input  logic clk,
    input  logic rst,
    input  logic in_async,
    output logic sig_s,
    output logic rise_c,
    output logic fall_c
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = in_async;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sig_s  = sync_q;
    assign rise_c = sync_q & ~prev_q;
    assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/rgb_sinp.sv
// WS2812b serial-in decoder: measures high/low times of the synchronized input,
// assembles 24-bit G-R-B words and writes colour / stream-reset words to a FIFO.
// Optional statistics counters are enabled with `define RGB_SINP_STATS_EN.
module rgb_sinp
    import rgb_pkg::*;
#(
    parameter int unsigned T_HIGH_MIN   = 8,
    parameter int unsigned T_BIT_THRESH = 58,
    parameter int unsigned T_HIGH_MAX   = 144,
    parameter int unsigned STR_RST      = 4800,
    parameter int unsigned COUNTER_MAX  = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_sig,
    input  logic              in_wr_fifo_full,
    output logic              out_wr_fifo_en,
    output logic [WORD_W-1:0] out_wr_fifo_data,
    output logic              out_err,
    output logic              out_overflow
`ifdef RGB_SINP_STATS_EN
    ,
    output logic [15:0]       out_word_cnt,
    output logic [7:0]        out_drop_cnt
`endif
);

    localparam int unsigned CNT_W  = $clog2(COUNTER_MAX + 1);
    localparam int unsigned BCNT_W = $clog2(BITS_PER_WORD + 1);

    localparam logic [CNT_W-1:0]  CNT_SAT      = CNT_W'(COUNTER_MAX);
    localparam logic [CNT_W-1:0]  CNT_HIGH_MIN = CNT_W'(T_HIGH_MIN);
    localparam logic [CNT_W-1:0]  CNT_BIT_ONE  = CNT_W'(T_BIT_THRESH);
    localparam logic [CNT_W-1:0]  CNT_HIGH_MAX = CNT_W'(T_HIGH_MAX);
    localparam logic [CNT_W-1:0]  CNT_STR_RST  = CNT_W'(STR_RST);
    localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
    localparam logic [BCNT_W-1:0] BCNT_LAST    = BCNT_W'(BITS_PER_WORD - 1);

    logic sig_s, rise_c, fall_c;

    rgb_sinp_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .in_async (in_sig),
        .sig_s    (sig_s),
        .rise_c   (rise_c),
        .fall_c   (fall_c)
    );

    sinp_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BCNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [BITS_PER_WORD-1:0]  shift_q, shift_d;
    logic                      armed_q, armed_d;
    logic                      wr_en_q, wr_en_d;
    logic [WORD_W-1:0]         wr_data_q, wr_data_d;
    logic                      err_q, err_d;
    logic                      ovf_q, ovf_d;

    logic                      emit_c;
    logic [WORD_W-1:0]         emit_word_c;
    logic                      bit_c;
    logic [CNT_W-1:0]          cnt_inc_c;

    assign cnt_inc_c = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        armed_d     = armed_q;
        err_d       = err_q;
        ovf_d       = ovf_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        emit_c      = 1'b0;
        emit_word_c = '0;
        bit_c       = 1'b0;

        case (state_q)
            IDLE_LOW: begin
                if (rise_c) begin
                    cnt_d   = CNT_ONE;
                    state_d = MEAS_HIGH;
                end
            end
            MEAS_HIGH: begin
                if (fall_c) begin
                    cnt_d   = CNT_ONE;
                    state_d = MEAS_LOW;
                    // Pulses shorter than the glitch floor leave the word untouched.
                    if (cnt_q >= CNT_HIGH_MIN) begin
                        bit_c   = (cnt_q >= CNT_BIT_ONE);
                        shift_d = {shift_q[BITS_PER_WORD-2:0], bit_c};
                        armed_d = 1'b1;
                        if (bit_cnt_q == BCNT_LAST) begin
                            emit_c      = 1'b1;
                            emit_word_c = data_word(shift_d);
                            bit_cnt_d   = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                        end
                    end
                end else if (cnt_q >= CNT_HIGH_MAX) begin
                    err_d     = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ERR_HIGH;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            ERR_HIGH: begin
                if (!sig_s) begin
                    cnt_d   = CNT_ONE;
                    state_d = MEAS_LOW;
                end
            end
            MEAS_LOW: begin
                if (rise_c) begin
                    cnt_d   = CNT_ONE;
                    state_d = MEAS_HIGH;
                end else if (cnt_q == CNT_STR_RST) begin
                    if (armed_q) begin
                        emit_c      = 1'b1;
                        emit_word_c = str_rst_word(bit_cnt_q != '0);
                    end
                    bit_cnt_d = '0;
                    armed_d   = 1'b0;
                    state_d   = IDLE_LOW;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            default: state_d = IDLE_LOW;
        endcase

        // A full FIFO drops the word for good; decoding carries on regardless.
        if (emit_c) begin
            if (in_wr_fifo_full) begin
                ovf_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_data_d = emit_word_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE_LOW;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            armed_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            armed_q   <= armed_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_wr_fifo_en   = wr_en_q;
    assign out_wr_fifo_data = wr_data_q;
    assign out_err          = err_q;
    assign out_overflow     = ovf_q;

`ifdef RGB_SINP_STATS_EN
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    // Written words wrap; dropped words saturate.
    always_comb begin
        word_cnt_d = word_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (emit_c) begin
            if (in_wr_fifo_full) begin
                if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
            end else begin
                word_cnt_d = word_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign out_word_cnt = word_cnt_q;
    assign out_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rgb_sinp.sv
// Bench for rgb_sinp: table-driven directed words, hand-written corner sequences,
// and randomized pulse trains checked against a pulse-level decoding model.
module tb_rgb_sinp;

    localparam int T_HIGH_MIN   = 8;
    localparam int T_BIT_THRESH = 58;
    localparam int T_HIGH_MAX   = 144;
    localparam int STR_RST      = 4800;
    localparam int LONG_LOW     = 4850;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_sig;
    logic        fifo_full;
    logic        out_wr_fifo_en;
    logic [31:0] out_wr_fifo_data;
    logic        out_err;
    logic        out_overflow;
`ifdef RGB_SINP_STATS_EN
    logic [15:0] out_word_cnt;
    logic [7:0]  out_drop_cnt;
`endif

    rgb_sinp dut (
        .clk              (clk),
        .rst              (rst),
        .in_sig           (in_sig),
        .in_wr_fifo_full  (fifo_full),
        .out_wr_fifo_en   (out_wr_fifo_en),
        .out_wr_fifo_data (out_wr_fifo_data),
        .out_err          (out_err),
        .out_overflow     (out_overflow)
`ifdef RGB_SINP_STATS_EN
        ,
        .out_word_cnt     (out_word_cnt),
        .out_drop_cnt     (out_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Observed FIFO writes.
    logic [31:0] got_q[$];
    logic        prev_en = 1'b0;

    always @(negedge clk) begin
        if (out_wr_fifo_en) begin
            got_q.push_back(out_wr_fifo_data);
            check("no_back_to_back_write", 32'(prev_en), 32'd0);
        end
        prev_en = out_wr_fifo_en;
    end

    // Pulse-level model: each high time and each low run is judged by the decoding rules.
    logic [31:0] model_q[$];
    int m_bitcnt, m_sr, m_writes, m_drops;
    bit m_armed, m_err, m_ovf;
    int low_run;
    bit judged;

    task automatic model_reset();
        m_bitcnt = 0; m_sr = 0; m_armed = 0; m_err = 0; m_ovf = 0;
        m_writes = 0; m_drops = 0; low_run = 0; judged = 1;
    endtask

    task automatic model_emit(input logic [31:0] w);
        if (fifo_full) begin
            m_ovf = 1;
            m_drops++;
        end else begin
            model_q.push_back(w);
            m_writes++;
        end
    endtask

    task automatic model_high(input int h);
        if (h < T_HIGH_MIN) return;
        if (h > T_HIGH_MAX) begin
            m_err = 1;
            m_bitcnt = 0;
            return;
        end
        m_sr = ((m_sr << 1) | (h >= T_BIT_THRESH ? 1 : 0)) & 32'h00FF_FFFF;
        m_bitcnt++;
        m_armed = 1;
        if (m_bitcnt == 24) begin
            model_emit(32'h8000_0000 | m_sr);
            m_bitcnt = 0;
        end
    endtask

    task automatic model_judge_low();
        if (!judged && low_run >= STR_RST) begin
            judged = 1;
            if (m_armed) model_emit(32'hC000_0000 | (m_bitcnt != 0 ? 32'h2000_0000 : 32'h0));
            m_bitcnt = 0;
            m_armed = 0;
        end
    endtask

    task automatic drive_low(input int n);
        in_sig = 1'b0;
        low_run += n;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_high(input int n);
        model_judge_low();
        in_sig = 1'b1;
        repeat (n) @(negedge clk);
        in_sig = 1'b0;
        model_high(n);
        low_run = 0;
        judged = 0;
    endtask

    task automatic send_bit(input bit b);
        if (b) begin drive_high(77); drive_low(43); end
        else   begin drive_high(38); drive_low(82); end
    endtask

    // Sends bits [hi:lo] of a 24-bit value, MSB first.
    task automatic send_bits(input logic [23:0] v, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(v[i]);
    endtask

    task automatic compare_words(input string name, input logic [31:0] exp_q[$]);
        check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(name, got_q[i], exp_q[i]);
        got_q.delete();
        model_q.delete();
    endtask

    typedef struct {
        logic [23:0] grb;
        int          nbits;
        int          nexp;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t        tbl[3];
    logic [31:0] dq[$];

    initial begin
        tbl[0] = '{grb: 24'hFF0080, nbits: 24, nexp: 2, exp0: 32'h80FF0080, exp1: 32'hC0000000};
        tbl[1] = '{grb: 24'hB6D000, nbits: 10, nexp: 1, exp0: 32'hE0000000, exp1: 32'h0};
        tbl[2] = '{grb: 24'h5A3C96, nbits: 24, nexp: 2, exp0: 32'h805A3C96, exp1: 32'hC0000000};

        rst = 1'b1; in_sig = 1'b0; fifo_full = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_en",   32'(out_wr_fifo_en), 32'd0);
        check("reset_data", out_wr_fifo_data,     32'd0);
        check("reset_err",  32'(out_err),         32'd0);
        check("reset_ovf",  32'(out_overflow),    32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Table: word (or partial word) followed by a stream-reset gap.
        for (int t = 0; t < 3; t++) begin
            send_bits(tbl[t].grb, 23, 24 - tbl[t].nbits);
            drive_low(LONG_LOW);
            model_judge_low();
            dq.delete();
            dq.push_back(tbl[t].exp0);
            if (tbl[t].nexp > 1) dq.push_back(tbl[t].exp1);
            compare_words("table_words", dq);
        end

        // Short high glitch between bits is ignored.
        send_bits(24'h123456, 23, 12);
        drive_high(5); drive_low(40);
        send_bits(24'h123456, 11, 0);
        drive_low(LONG_LOW);
        model_judge_low();
        dq.delete(); dq.push_back(32'h80123456); dq.push_back(32'hC0000000);
        compare_words("glitch_words", dq);
        check("glitch_err", 32'(out_err), 32'd0);

        // Overlong high mid-word: error flag, partial word discarded.
        send_bits(24'h3C3C3C, 23, 14);
        drive_high(200); drive_low(100);
        check("err_set", 32'(out_err), 32'd1);
        send_bits(24'hA5A5A5, 23, 0);
        drive_low(LONG_LOW);
        model_judge_low();
        dq.delete(); dq.push_back(32'h80A5A5A5); dq.push_back(32'hC0000000);
        compare_words("err_words", dq);
        check("err_sticky", 32'(out_err), 32'd1);

        // Full FIFO on the 24th bit drops the word; next word writes normally.
        send_bits(24'h654321, 23, 1);
        fifo_full = 1'b1;
        send_bits(24'h654321, 0, 0);
        fifo_full = 1'b0;
        check("ovf_set", 32'(out_overflow), 32'd1);
        dq.delete();
        compare_words("ovf_dropped", dq);
        send_bits(24'h0F0F0F, 23, 0);
        dq.delete(); dq.push_back(32'h800F0F0F);
        compare_words("ovf_next_word", dq);
        check("ovf_sticky", 32'(out_overflow), 32'd1);

        // Reset mid-word: everything clears, aborted bits leave no trace.
        send_bits(24'hFFF000, 23, 12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midrst_en",   32'(out_wr_fifo_en), 32'd0);
        check("midrst_data", out_wr_fifo_data,     32'd0);
        check("midrst_err",  32'(out_err),         32'd0);
        check("midrst_ovf",  32'(out_overflow),    32'd0);
        send_bits(24'h00FF00, 23, 0);
        drive_low(LONG_LOW);
        model_judge_low();
        dq.delete(); dq.push_back(32'h8000FF00); dq.push_back(32'hC0000000);
        compare_words("midrst_words", dq);

        // Randomized pulse trains against the model.
        model_q.delete();
        for (int it = 0; it < 4; it++) begin
            int nb;
            int sel;
            sel = int'($urandom_range(3, 0));
            nb  = (sel < 2) ? 24 : (sel == 2) ? int'($urandom_range(23, 1)) : 30;
            for (int b = 0; b < nb; b++) begin
                bit v;
                v = 1'($urandom_range(1, 0));
                if ($urandom_range(7, 0) == 0) begin
                    drive_high(int'($urandom_range(6, 1)));
                    drive_low(int'($urandom_range(40, 20)));
                end
                fifo_full = ($urandom_range(9, 0) == 0);
                if (v) begin
                    drive_high(int'($urandom_range(100, 64)));
                    drive_low(int'($urandom_range(40, 15)));
                end else begin
                    drive_high(int'($urandom_range(50, 12)));
                    drive_low(int'($urandom_range(40, 20)));
                end
                fifo_full = 1'b0;
            end
            drive_low(LONG_LOW);
            model_judge_low();
            dq = model_q;
            compare_words("rand_words", dq);
            check("rand_err", 32'(out_err),      32'(m_err));
            check("rand_ovf", 32'(out_overflow), 32'(m_ovf));
        end
`ifdef RGB_SINP_STATS_EN
        check("stats_words", 32'(out_word_cnt), 32'(m_writes));
        check("stats_drops", 32'(out_drop_cnt), 32'(m_drops));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
